// File: rtl/pio_pkg.sv
// Shared types and constants for the PIO instruction-fetch slice.
package pio_pkg;

  localparam logic [15:0] NOP_INSTR = 16'hA042;  // mov y,y

  // The delay/side-set field occupies instr[12:8]; side-set bits take its top end.
  localparam int unsigned FIELD_MSB = 12;
  localparam int unsigned FIELD_LSB = 8;
  localparam int unsigned FIELD_W   = FIELD_MSB - FIELD_LSB + 1;

  typedef enum logic [2:0] {
    OpJmp, OpWait, OpIn, OpOut, OpPushPull, OpMov, OpIrq, OpSet
  } opcode_e;

  typedef enum logic [0:0] {StExec, StDelay} fsm_t;

  // Illegal side-set counts above 5 behave as 5.
  function automatic logic [2:0] clamp_sideset(input logic [2:0] count);
    return (count > 3'd5) ? 3'd5 : count;
  endfunction

endpackage

// File: rtl/pio_delay_counter.sv
// Delay-cycle counter: clear beats load beats decrement.
module pio_delay_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pio_instr_fetch.sv
// PIO instruction fetch/delay stage: instruction memory, delay FSM, side-set decode.
// Define PIO_FETCH_READBACK_EN to add a combinational debug read port (dbg_raddr/dbg_rdata).
module pio_instr_fetch #(
  parameter int unsigned          ADDR_W    = 5,
  parameter int unsigned          INSTR_W   = 16,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = pio_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               penable,
  input  logic               imm,
  input  logic [INSTR_W-1:0] imm_instr,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               mem_we,
  input  logic [ADDR_W-1:0]  mem_waddr,
  input  logic [INSTR_W-1:0] mem_wdata,
  input  logic [2:0]         sideset_count,
  input  logic               side_en,
  input  logic               exec_stalled,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_imm,
  output logic               stall,
  output logic [4:0]         sideset_val,
  output logic               sideset_valid,
  output logic               delay_active
`ifdef PIO_FETCH_READBACK_EN
  ,
  input  logic [ADDR_W-1:0]  dbg_raddr,
  output logic [INSTR_W-1:0] dbg_rdata
`endif
);

  import pio_pkg::*;

  logic [INSTR_W-1:0] mem [2**ADDR_W];
  logic [INSTR_W-1:0] instr_q;
  logic               instr_imm_q;
  logic               first_q;
  fsm_t               state_q;

  logic [2:0]         sc;
  logic [FIELD_W-1:0] field, d, ss_raw;
  logic               ss_enabled;
  logic               fetch;
  logic               cnt_zero, cnt_clear, cnt_load, cnt_dec;

  // Delay is the low (5 - sideset_count) bits of the field; side-set is the rest.
  always_comb begin
    sc          = clamp_sideset(sideset_count);
    field       = instr_q[FIELD_MSB:FIELD_LSB];
    d           = instr_imm_q ? '0 : (field & (5'h1f >> sc));
    ss_raw      = field >> (3'd5 - sc);
    ss_enabled  = 1'b0;
    sideset_val = '0;
    if (sc != 3'd0) begin
      if (side_en) begin
        ss_enabled  = ss_raw[sc - 3'd1];
        sideset_val = ss_raw & ~(5'd1 << (sc - 3'd1));
      end else begin
        ss_enabled  = 1'b1;
        sideset_val = ss_raw;
      end
    end
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      StExec:  stall = exec_stalled | (d != '0);
      StDelay: stall = ~cnt_zero & ~imm;  // a forced instruction preempts the delay
      default: stall = 1'b0;
    endcase
  end

  assign fetch     = (penable | imm) & ~stall;
  assign cnt_load  = (state_q == StExec) & penable & ~exec_stalled & (d != '0);
  assign cnt_clear = (state_q == StDelay) & imm;
  assign cnt_dec   = (state_q == StDelay) & ~imm & penable & ~cnt_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StExec;
    end else begin
      case (state_q)
        StExec:  if (cnt_load) state_q <= StDelay;
        StDelay: if (imm || (penable && cnt_zero)) state_q <= StExec;
        default: state_q <= StExec;
      endcase
    end
  end

  pio_delay_counter #(
    .WIDTH (FIELD_W)
  ) u_delay_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (d - 5'd1),
    .zero     (cnt_zero)
  );

  // No reset on the array: program contents survive a state-machine reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q     <= NOP_INSTR;
      instr_imm_q <= 1'b0;
      first_q     <= 1'b1;
    end else if (fetch) begin
      instr_q     <= imm ? imm_instr : mem[pc];
      instr_imm_q <= imm;
      first_q     <= 1'b1;
    end else if (penable) begin
      first_q     <= 1'b0;
    end
  end

  assign instr         = instr_q;
  assign instr_imm     = instr_imm_q;
  assign delay_active  = (state_q == StDelay);
  assign sideset_valid = first_q & penable & ss_enabled & (sc != 3'd0);

`ifdef PIO_FETCH_READBACK_EN
  assign dbg_rdata = mem[dbg_raddr];
`endif

endmodule

// File: tb/tb_pio_instr_fetch.sv
// Directed bench for pio_instr_fetch with hand-computed expectations.
module tb_pio_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        penable, imm, mem_we, side_en, exec_stalled;
  logic [15:0] imm_instr, mem_wdata;
  logic [4:0]  pc, mem_waddr;
  logic [2:0]  sideset_count;
  logic [15:0] instr;
  logic        instr_imm, stall, sideset_valid, delay_active;
  logic [4:0]  sideset_val;
`ifdef PIO_FETCH_READBACK_EN
  logic [4:0]  dbg_raddr;
  logic [15:0] dbg_rdata;
`endif

  int nvec = 0;
  int nerr = 0;
  int pulses;

  always #5 clk = ~clk;

  pio_instr_fetch dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .penable       (penable),
    .imm           (imm),
    .imm_instr     (imm_instr),
    .pc            (pc),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .sideset_count (sideset_count),
    .side_en       (side_en),
    .exec_stalled  (exec_stalled),
    .instr         (instr),
    .instr_imm     (instr_imm),
    .stall         (stall),
    .sideset_val   (sideset_val),
    .sideset_valid (sideset_valid),
    .delay_active  (delay_active)
`ifdef PIO_FETCH_READBACK_EN
    ,
    .dbg_raddr     (dbg_raddr),
    .dbg_rdata     (dbg_rdata)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] w);
    mem_we = 1'b1; mem_waddr = a; mem_wdata = w;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int stall_seq[5];
    int delay_seq[5];
    stall_seq = '{1, 1, 1, 1, 0};
    delay_seq = '{0, 1, 1, 1, 1};
    reset_n = 1'b0; penable = 0; imm = 0; imm_instr = '0; pc = '0; mem_we = 0;
    mem_waddr = '0; mem_wdata = '0; sideset_count = '0; side_en = 0; exec_stalled = 0;
`ifdef PIO_FETCH_READBACK_EN
    dbg_raddr = '0;
`endif
    repeat (2) tick();
    #1;
    check("rst_instr", 32'(instr), 32'hA042);
    check("rst_imm", 32'(instr_imm), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_delay", 32'(delay_active), 0);
    check("rst_ssvalid", 32'(sideset_valid), 0);
    reset_n = 1'b1;

    wr(5'd1, 16'h0800); wr(5'd3, 16'h0400); wr(5'd5, 16'h1A00);
    wr(5'd7, 16'h1000); wr(5'd2, 16'h0700); wr(5'd9, 16'hA011);

    // Reset in the middle of a delay (d=8 -> cnt=7)
    pc = 5'd1; penable = 1;
    tick();
    #1 check("t1_instr", 32'(instr), 32'h0800);
    check("t1_stall", 32'(stall), 1);
    tick();
    #1 check("t1_delay", 32'(delay_active), 1);
    penable = 0; reset_n = 1'b0;
    tick();
    #1 check("t1_rst_instr", 32'(instr), 32'hA042);
    check("t1_rst_stall", 32'(stall), 0);
    check("t1_rst_delay", 32'(delay_active), 0);
    reset_n = 1'b1;

    // d=4: stall for 4 cycles, 5 cycles total
    pc = 5'd3; penable = 1;
    #1 check("t2_stall0", 32'(stall), 0);
    tick();
    #1 check("t2_instr", 32'(instr), 32'h0400);
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("t2_stall%0d", i), 32'(stall), 32'(stall_seq[i]));
      check($sformatf("t2_delay%0d", i), 32'(delay_active), 32'(delay_seq[i]));
      tick();
    end
    penable = 0;
    do_reset();

    // Side-set 3 bits with enable: field 11010 -> value 2'b10, d=2
    sideset_count = 3'd3; side_en = 1; pc = 5'd5; penable = 1;
    #1 check("t3_nop_valid", 32'(sideset_valid), 0);
    tick();
    #1 check("t3_instr", 32'(instr), 32'h1A00);
    check("t3_ssval", 32'(sideset_val), 2);
    check("t3_ssvalid", 32'(sideset_valid), 1);
    check("t3_stall1", 32'(stall), 1);
    tick();
    #1 check("t3_ssvalid2", 32'(sideset_valid), 0);
    check("t3_stall2", 32'(stall), 1);
    tick();
    #1 check("t3_stall3", 32'(stall), 0);
    penable = 0;
    do_reset();

    // exec_stalled for 3 cycles: side-set applied exactly once
    sideset_count = 3'd2; side_en = 0; pc = 5'd7; penable = 1;
    tick();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      exec_stalled = (i < 3);
      #1 check($sformatf("t4_stall%0d", i), 32'(stall), (i < 3) ? 1 : 0);
      if (i == 0) check("t4_ssval", 32'(sideset_val), 2);
      pulses += int'(sideset_valid);
      tick();
    end
    check("t4_pulses", 32'(pulses), 1);
    exec_stalled = 0; penable = 0; sideset_count = 3'd0;
    do_reset();

    // imm preempts a delay (d=7 -> cnt 6,5)
    pc = 5'd2; penable = 1;
    tick();
    tick();
    tick();
    #1 check("t5_delay", 32'(delay_active), 1);
    check("t5_stall", 32'(stall), 1);
    imm = 1; imm_instr = 16'h0600;
    #1 check("t5_imm_stall", 32'(stall), 0);
    tick();
    imm = 0;
    #1 check("t5_instr", 32'(instr), 32'h0600);
    check("t5_instr_imm", 32'(instr_imm), 1);
    check("t5_delay_off", 32'(delay_active), 0);
    check("t5_no_stall", 32'(stall), 0);
    // Illegal sideset_count=7 acts as 5: whole field is side-set
    imm = 1; imm_instr = 16'h1A00; sideset_count = 3'd7; side_en = 0;
    tick();
    imm = 0;
    #1 check("t5_ss7_val", 32'(sideset_val), 26);
    check("t5_ss7_valid", 32'(sideset_valid), 1);
    check("t5_ss7_stall", 32'(stall), 0);
    penable = 0; sideset_count = 3'd0;
    do_reset();

    // Write and fetch of the same address in one cycle latch old data
    pc = 5'd9; penable = 1;
    mem_we = 1; mem_waddr = 5'd9; mem_wdata = 16'hA022;
    tick();
    mem_we = 0;
    #1 check("t6_old", 32'(instr), 32'hA011);
    tick();
    #1 check("t6_new", 32'(instr), 32'hA022);
    penable = 0;
`ifdef PIO_FETCH_READBACK_EN
    dbg_raddr = 5'd3;
    #1 check("dbg_rdata", 32'(dbg_rdata), 32'h0400);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
